mole_round_ctrl: RTL

- Game-round controller that consumes the 8-bit pseudo-random value from the LFSR random generator directly upstream.
- Each round it waits a random delay, lights one random target of N_TARGETS, then grades the player's button press as a hit or a miss.
- It keeps score and a round count, and its outputs drive the LED/FND display logic downstream.

---
 rtl/mole_round_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: random pre-delay, one lit target, hit/miss grading, score and round count.
// Optional MOLE_NO_REPEAT_EN: never light the same target index twice in a row.
module mole_round_ctrl #(
  parameter int N_TARGETS    = 8,
  parameter int MIN_DELAY    = 4,
  parameter int ACTIVE_TICKS = 16,
  parameter int ROUNDS       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tick,
  input  logic [7:0]           rand_num,
  input  logic [N_TARGETS-1:0] btn,
  output logic [N_TARGETS-1:0] target,
  output logic                 hit,
  output logic                 miss,
  output logic [7:0]           score,
  output logic [7:0]           round_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (N_TARGETS > 2) ? $clog2(N_TARGETS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACTIVE, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [7:0]     r_cnt, r_dly_len, r_score, r_round_cnt;
  logic [IW-1:0]  r_idx;
  logic           r_hit, r_miss;

  logic [7:0]           w_cnt_inc;
  logic [8:0]           w_rc_inc;
  logic [IW-1:0]        w_idx_raw, w_idx_sel;
  logic [N_TARGETS-1:0] w_target_vec;
  logic w_game_start, w_hit_ev, w_wrong_ev, w_timeout_ev, w_miss_ev, w_round_end;
  logic w_last_round, w_enter_delay, w_enter_active, w_running;
  logic w_unused;

  assign w_unused     = rand_num[4];
  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_rc_inc     = {1'b0, r_round_cnt} + 9'd1;
  assign w_target_vec = {{(N_TARGETS-1){1'b0}}, 1'b1} << r_idx;
  assign w_running    = (r_state == S_DELAY) || (r_state == S_ACTIVE);

  // Grading priority: exact match, then any press, then timeout.
  assign w_game_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hit_ev     = (r_state == S_ACTIVE) && (btn == w_target_vec);
  assign w_wrong_ev   = (r_state == S_ACTIVE) && !w_hit_ev && (btn != '0);
  assign w_timeout_ev = (r_state == S_ACTIVE) && (btn == '0) && tick &&
                        (w_cnt_inc == 8'(ACTIVE_TICKS));
  assign w_miss_ev    = w_wrong_ev || w_timeout_ev;
  assign w_round_end  = w_hit_ev || w_miss_ev;
  assign w_last_round = (w_rc_inc >= 9'(ROUNDS));

  assign w_enter_delay  = w_game_start || (w_round_end && !w_last_round);
  assign w_enter_active = (r_state == S_DELAY) && tick && (w_cnt_inc == r_dly_len);

  assign w_idx_raw = IW'(rand_num[7:5] & 3'(N_TARGETS - 1));
`ifdef MOLE_NO_REPEAT_EN
  assign w_idx_sel = (w_idx_raw == r_idx) ? w_idx_raw + IW'(1) : w_idx_raw;
`else
  assign w_idx_sel = w_idx_raw;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_game_start) w_state_next = S_DELAY;
      S_DELAY:        if (w_enter_active) w_state_next = S_ACTIVE;
      S_ACTIVE:       if (w_round_end) w_state_next = w_last_round ? S_DONE : S_DELAY;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    target = '0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_DELAY:  busy = 1'b1;
      S_ACTIVE: begin
        busy   = 1'b1;
        target = w_target_vec;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dly_len   <= '0;
      r_score     <= '0;
      r_round_cnt <= '0;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_hit  <= w_hit_ev;
      r_miss <= w_miss_ev;

      if (w_game_start) begin
        r_score     <= '0;
        r_round_cnt <= '0;
      end else begin
        if (w_hit_ev && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
        if (w_round_end)                    r_round_cnt <= w_rc_inc[7:0];
      end

      if (w_enter_delay) begin
        r_dly_len <= 8'(MIN_DELAY) + {4'd0, rand_num[3:0]};
        r_cnt     <= '0;
      end else if (w_enter_active) begin
        r_idx <= w_idx_sel;
        r_cnt <= '0;
      end else if (tick && w_running) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign hit       = r_hit;
  assign miss      = r_miss;
  assign score     = r_score;
  assign round_cnt = r_round_cnt;

endmodule
